// File: rtl/mem_block_initiator.sv
// Request-side controller for a byte-addressed 16-bit memory: single-word writes and BLOCK_WORDS-word block fills.
// Optional `MEM_BLOCK_CRITICAL_WORD_EN: start each fill at the requested word and wrap around the block.
module mem_block_initiator #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 0,
    localparam int IDX_W      = $clog2(BLOCK_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wr_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [15:0]           req_wdata_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_enable_o,
    output logic                  mem_wr_o,
    output logic [15:0]           mem_wdata_o,
    input  logic [15:0]           mem_rdata_i,
    output logic                  fill_valid_o,
    output logic [IDX_W-1:0]      fill_idx_o,
    output logic [15:0]           fill_data_o,
    output logic                  done_o
);

    localparam int HOLD_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [IDX_W-1:0]        w_q, w_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic                    fill_valid_q, fill_valid_d;
    logic [IDX_W-1:0]        fill_idx_q, fill_idx_d;
    logic [15:0]             fill_data_q, fill_data_d;
    logic [IDX_W-1:0]        start_idx;
    logic [ADDR_WIDTH-1:0]   rd_addr;

`ifdef MEM_BLOCK_CRITICAL_WORD_EN
    assign start_idx = req_addr_i[IDX_W:1];
`else
    assign start_idx = '0;
`endif

    // Read address: block base from the latched address, word field from the wrapping index.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_rd_addr
            if (gi == 0) begin : g_lsb
                assign rd_addr[gi] = 1'b0;
            end else if (gi <= IDX_W) begin : g_idx
                assign rd_addr[gi] = w_q[gi-1];
            end else begin : g_base
                assign rd_addr[gi] = addr_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            w_q          <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            fill_valid_q <= 1'b0;
            fill_idx_q   <= '0;
            fill_data_q  <= '0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            w_q          <= w_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            fill_valid_q <= fill_valid_d;
            fill_idx_q   <= fill_idx_d;
            fill_data_q  <= fill_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        w_d          = w_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        fill_valid_d = 1'b0;
        fill_idx_d   = fill_idx_q;
        fill_data_d  = fill_data_q;
        req_ready_o  = 1'b0;
        mem_enable_o = 1'b0;
        mem_wr_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        done_o       = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = ~rst;
                if (req_valid_i) begin
                    addr_d  = req_addr_i & ~ADDR_WIDTH'(1);
                    wdata_d = req_wdata_i;
                    w_d     = start_idx;
                    cnt_d   = '0;
                    hold_d  = '0;
                    state_d = req_wr_i ? WRITE : READ;
                end
            end
            WRITE: begin
                mem_enable_o = 1'b1;
                mem_wr_o     = 1'b1;
                mem_addr_o   = addr_q;
                mem_wdata_o  = wdata_q;
                state_d      = DONE;
            end
            READ: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = rd_addr;
                // Data is sampled only on the final cycle the address is held.
                if (hold_q == HOLD_W'(MEM_LATENCY)) begin
                    hold_d       = '0;
                    fill_valid_d = 1'b1;
                    fill_idx_d   = w_q;
                    fill_data_d  = mem_rdata_i;
                    w_d          = w_q + 1'b1;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(BLOCK_WORDS - 1)) begin
                        state_d = DONE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fill_valid_o = fill_valid_q;
    assign fill_idx_o   = fill_idx_q;
    assign fill_data_o  = fill_data_q;

endmodule
